// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating starvation counter for the low-priority master.
module arb_wait_cnt #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [7:0] count;

  // Clear has priority so a grant in the same cycle restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_W)) begin
      count <= count + 8'd1;
    end
  end

  assign sat = (count == MAX_W);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master device-bus arbiter: master 0 fixed priority, master 1 anti-starvation.
// Optional BUSY timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        owner,
  output logic [1:0]  fsm_state
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
    $error("bus_arbiter: MAX_WAIT out of range 1..255");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT out of range 1..65535");
  end

  // Handshake: a master raises reqX with its addr/wdata/we and holds them until
  // ackX pulses for one cycle; rdataX/errX are valid with that pulse. On the
  // slave side bus_valid stays high with stable addr/wdata/we until bus_ack.

  state_t state, state_next;
  logic   req0_eff, req1_eff;
  logic   grant0, grant1;
  logic   done;
  logic   tmo_hit;
  logic   wait_sat;

  assign req0_eff = req0 & ~ack0;
  assign req1_eff = req1 & ~ack1;

  arb_wait_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .clk(clk),
    .rst(rst),
    .inc(req1_eff && (state != BUSY1)),
    .clr(!req1 || grant1),
    .sat(wait_sat)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!done) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A real bus_ack in the final cycle takes precedence over the timeout.
  assign tmo_hit = (state != IDLE) && !bus_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= done && (state == BUSY0) && tmo_hit;
      err1 <= done && (state == BUSY1) && tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err0    = 1'b0;
  assign err1    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (req1_eff && (wait_sat || !req0_eff)) begin
          grant1     = 1'b1;
          state_next = BUSY1;
        end else if (req0_eff) begin
          grant0     = 1'b1;
          state_next = BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (bus_ack || tmo_hit) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      owner     <= M0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant0) begin
        bus_addr  <= addr0;
        bus_wdata <= wdata0;
        bus_we    <= we0;
        owner     <= M0;
      end else if (grant1) begin
        bus_addr  <= addr1;
        bus_wdata <= wdata1;
        bus_we    <= we1;
        owner     <= M1;
      end
      if (done) begin
        bus_we <= 1'b0;
        if (state == BUSY0) begin
          ack0   <= 1'b1;
          rdata0 <= tmo_hit ? ERR_RDATA : bus_rdata;
        end else begin
          ack1   <= 1'b1;
          rdata1 <= tmo_hit ? ERR_RDATA : bus_rdata;
        end
      end
    end
  end

  assign bus_valid = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus multi-cycle corner sequences.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        bus_valid, bus_we, bus_ack, owner;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  bus_arbiter #(
    .MAX_WAIT(8),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .owner(owner), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_owner;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_rdata0;
    logic [31:0] e_rdata1;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(
    logic r0, logic [31:0] a0, logic [31:0] d0, logic w0,
    logic r1, logic [31:0] a1, logic [31:0] d1, logic w1,
    logic ba, logic [31:0] br,
    logic ev, logic [31:0] ea, logic [31:0] ed, logic ew, logic eo,
    logic ek0, logic ek1, logic [31:0] er0, logic [31:0] er1);
    vec_t v;
    v.req0 = r0; v.addr0 = a0; v.wdata0 = d0; v.we0 = w0;
    v.req1 = r1; v.addr1 = a1; v.wdata1 = d1; v.we1 = w1;
    v.bus_ack = ba; v.bus_rdata = br;
    v.e_valid = ev; v.e_addr = ea; v.e_wdata = ed; v.e_we = ew; v.e_owner = eo;
    v.e_ack0 = ek0; v.e_ack1 = ek1; v.e_rdata0 = er0; v.e_rdata1 = er1;
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; addr0 = '0; wdata0 = '0; we0 = 1'b0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0; we1 = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic prev_valid;

  initial begin
    // Single read, held request, write path, idle ack, back-to-back handover.
    vecs[0]  = mk(1, 32'h7F00, 0, 0,  0, 0, 0, 0,  0, 0,
                  1, 32'h7F00, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 32'h7F00, 0, 0,  0, 0, 0, 0,  0, 0,
                  1, 32'h7F00, 0, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk(1, 32'h7F00, 0, 0,  0, 0, 0, 0,  1, 32'h1234,
                  0, 0, 0, 0, 0,  1, 0, 32'h1234, 0);
    vecs[3]  = mk(1, 32'h7F00, 0, 0,  0, 0, 0, 0,  0, 0,
                  0, 0, 0, 0, 0,  0, 0, 32'h1234, 0);
    vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0,
                  0, 0, 0, 0, 0,  0, 0, 32'h1234, 0);
    vecs[5]  = mk(0, 0, 0, 0,  1, 32'h7F10, 32'hA5A5A5A5, 1,  0, 0,
                  1, 32'h7F10, 32'hA5A5A5A5, 1, 1,  0, 0, 32'h1234, 0);
    vecs[6]  = mk(0, 0, 0, 0,  1, 0, 0, 0,  0, 0,
                  1, 32'h7F10, 32'hA5A5A5A5, 1, 1,  0, 0, 32'h1234, 0);
    vecs[7]  = mk(0, 0, 0, 0,  1, 0, 0, 0,  1, 32'hCAFE0001,
                  0, 0, 0, 0, 1,  0, 1, 32'h1234, 32'hCAFE0001);
    vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0,
                  0, 0, 0, 0, 1,  0, 0, 32'h1234, 32'hCAFE0001);
    vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 32'hFFFFFFFF,
                  0, 0, 0, 0, 1,  0, 0, 32'h1234, 32'hCAFE0001);
    vecs[10] = mk(1, 32'h100, 32'h55, 0,  0, 0, 0, 0,  0, 0,
                  1, 32'h100, 32'h55, 0, 0,  0, 0, 32'h1234, 32'hCAFE0001);
    vecs[11] = mk(1, 32'h100, 32'h55, 0,  1, 32'h200, 32'h66, 1,  1, 32'h11,
                  0, 0, 0, 0, 0,  1, 0, 32'h11, 32'hCAFE0001);
    vecs[12] = mk(1, 32'h100, 32'h55, 0,  1, 32'h200, 32'h66, 1,  0, 0,
                  1, 32'h200, 32'h66, 1, 1,  0, 0, 32'h11, 32'hCAFE0001);
    vecs[13] = mk(1, 32'h100, 32'h55, 0,  1, 32'h200, 32'h66, 1,  1, 32'h22,
                  0, 0, 0, 0, 1,  0, 1, 32'h11, 32'h22);
    vecs[14] = mk(1, 32'h100, 32'h55, 0,  1, 32'h200, 32'h66, 1,  0, 0,
                  1, 32'h100, 32'h55, 0, 0,  0, 0, 32'h11, 32'h22);
    vecs[15] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 32'h33,
                  0, 0, 0, 0, 0,  1, 0, 32'h33, 32'h22);
    vecs[16] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0,
                  0, 0, 0, 0, 0,  0, 0, 32'h33, 32'h22);

    // reset state
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    chk("rst.valid", 32'(bus_valid), 0);
    chk("rst.state", 32'(fsm_state), 0);
    chk("rst.acks", {30'd0, ack0, ack1}, 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.rdata1", rdata1, 0);
    chk("rst.owner", 32'(owner), 0);
    rst = 1'b1;
    step();

    // vector table
    for (int i = 0; i < NV; i++) begin
      req0 = vecs[i].req0; addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0; we0 = vecs[i].we0;
      req1 = vecs[i].req1; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1; we1 = vecs[i].we1;
      bus_ack = vecs[i].bus_ack; bus_rdata = vecs[i].bus_rdata;
      step();
      chk($sformatf("v%0d.valid", i), 32'(bus_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d.we", i), 32'(bus_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d.owner", i), 32'(owner), 32'(vecs[i].e_owner));
      chk($sformatf("v%0d.ack0", i), 32'(ack0), 32'(vecs[i].e_ack0));
      chk($sformatf("v%0d.ack1", i), 32'(ack1), 32'(vecs[i].e_ack1));
      chk($sformatf("v%0d.rdata0", i), rdata0, vecs[i].e_rdata0);
      chk($sformatf("v%0d.rdata1", i), rdata1, vecs[i].e_rdata1);
      chk($sformatf("v%0d.errs", i), {30'd0, err0, err1}, 0);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d.addr", i), bus_addr, vecs[i].e_addr);
        chk($sformatf("v%0d.wdata", i), bus_wdata, vecs[i].e_wdata);
      end
    end

    // long BUSY0 lets master 1's wait counter saturate; it takes the next slot
    idle_inputs();
    req0 = 1'b1; addr0 = 32'h300;
    step();
    chk("a.grant0", 32'(owner), 0);
    req1 = 1'b1; addr1 = 32'h400;
    repeat (10) step();
    chk("a.still_busy", 32'(bus_valid), 1);
    chk("a.no_ack", {30'd0, ack0, ack1}, 0);
    bus_ack = 1'b1; bus_rdata = 32'h77;
    step();
    chk("a.ack0", 32'(ack0), 1);
    chk("a.rdata0", rdata0, 32'h77);
    bus_ack = 1'b0;
    step();
    chk("a.grant1.valid", 32'(bus_valid), 1);
    chk("a.grant1.owner", 32'(owner), 1);
    chk("a.grant1.addr", bus_addr, 32'h400);
    bus_ack = 1'b1; bus_rdata = 32'h88;
    step();
    chk("a.ack1", 32'(ack1), 1);
    chk("a.rdata1", rdata1, 32'h88);
    idle_inputs();
    step();
    step();

    // both requesting continuously with single-cycle bus_ack: strict alternation
    for (int i = 0; i < 12; i++) exp_q.push_back(1'(i % 2));
    for (int i = 0; i < 24; i++) begin
      req0 = 1'b1; addr0 = 32'h500;
      req1 = 1'b1; addr1 = 32'h600;
      bus_ack = bus_valid;
      bus_rdata = 32'(i);
      prev_valid = bus_valid;
      step();
      chk("b.overlap", 32'(ack0 & ack1), 0);
      if (bus_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("b.extra_grant", 32'(owner), 32'hFFFF_FFFF);
        end else begin
          chk("b.grant_owner", 32'(owner), 32'(exp_q.pop_front()));
          chk("b.grant_addr", bus_addr, owner ? 32'h600 : 32'h500);
        end
      end
    end
    chk("b.grants_left", 32'(exp_q.size()), 0);
    idle_inputs();
    step();
    step();

    // async reset while in BUSY1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h700; wdata1 = 32'h99;
    step();
    chk("c.busy1", 32'(fsm_state), 2);
    #3;
    rst = 1'b0;
    #1;
    chk("c.valid", 32'(bus_valid), 0);
    chk("c.we", 32'(bus_we), 0);
    chk("c.addr", bus_addr, 0);
    chk("c.wdata", bus_wdata, 0);
    chk("c.state", 32'(fsm_state), 0);
    chk("c.outs", {28'd0, ack0, ack1, owner, err1}, 0);
    chk("c.rdata", rdata0 | rdata1, 0);
    idle_inputs();
    bus_ack = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c.no_ack1", 32'(ack1), 0);
      chk("c.idle", 32'(bus_valid), 0);
    end
    bus_ack = 1'b0;

    // no bus_ack: timeout termination, or indefinite BUSY without the feature
    req0 = 1'b1; addr0 = 32'h800;
    step();
    req0 = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d.waiting", 32'(bus_valid), 1);
      chk("d.no_ack", 32'(ack0), 0);
    end
    step();
    chk("d.tmo_ack", 32'(ack0), 1);
    chk("d.tmo_err", 32'(err0), 1);
    chk("d.tmo_rdata", rdata0, 32'hDEAD_BEEF);
    chk("d.tmo_valid", 32'(bus_valid), 0);
    step();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    repeat (3) step();
    bus_ack = 1'b1; bus_rdata = 32'h5A;
    step();
    chk("d.race_ack", 32'(ack0), 1);
    chk("d.race_err", 32'(err0), 0);
    chk("d.race_rdata", rdata0, 32'h5A);
`else
    for (int i = 0; i < 8; i++) begin
      step();
      chk("d.waiting", 32'(bus_valid), 1);
      chk("d.no_ack", 32'(ack0), 0);
    end
    bus_ack = 1'b1; bus_rdata = 32'h5A;
    step();
    chk("d.late_ack", 32'(ack0), 1);
    chk("d.late_err", 32'(err0), 0);
    chk("d.late_rdata", rdata0, 32'h5A);
`endif
    idle_inputs();
    step();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
